ioc_cmd_initiator: RTL
======================

Name: ioc_cmd_initiator

Overview:
- Initiator side of the IOC register bus: turns the byte stream from the host SPI link into per-module i_cs / i_fetch_cmd / i_load_cmd / i_ioc / i_data_in strobes.
- Returns the selected module's o_data_out to the SPI transmit path.
- Sits between the SPI byte-level slave and the module register blocks (sys_ctrl, io_ctrl, smi_ctrl, ...).
- Fully synchronous to i_sys_clk; the SPI side is already synchronised byte-wise.

Parameters:
- NUM_MODULES, 4, number of responder modules; legal range 1..4.

Ports:
- i_sys_clk  in  1  system clock.
- i_rst_b  in  1  reset; asynchronous, active-low.
- i_frame_start  in  1  one-cycle pulse; SPI chip-select asserted.
- i_frame_end  in  1  one-cycle pulse; SPI chip-select released.
- i_rx_byte  in  8  received host byte.
- i_rx_valid  in  1  one-cycle pulse; i_rx_byte valid.
- o_tx_byte  out  8  response byte to the SPI shifter.
- o_tx_valid  out  1  one-cycle pulse; o_tx_byte valid.
- o_ioc  out  5  register address to modules.
- o_data_out  out  8  write data to modules.
- o_cs  out  NUM_MODULES  one-hot module select.
- o_fetch_cmd  out  1  read strobe.
- o_load_cmd  out  1  write strobe.
- i_data_in  in  8*NUM_MODULES  module read buses; module k occupies bits [8k+7:8k].
- o_busy  out  1  high in every state except IDLE.
- o_frame_err  out  1  one-cycle pulse on a truncated write or an out-of-range module.

Behaviour:
- Command byte format:
  - bit7 = dir (1 write, 0 read).
  - bits6:5 = module select.
  - bits4:0 = ioc.
- Reset values:
  - All outputs 0.
  - o_cs all-zero.
  - FSM in IDLE.
- All outputs are registered.
- FSM states: IDLE, CMD, WDATA, FETCH, CAPTURE, RESP, DONE.
- IDLE:
  - i_frame_start -> CMD.
  - i_rx_valid is ignored.
- CMD:
  - On i_rx_valid, latch dir/mod/ioc and drive o_ioc.
  - Module index >= NUM_MODULES: pulse o_frame_err, go to DONE; no strobes, no tx.
  - Write -> WDATA.
  - Read -> FETCH.
- FETCH (read), one cycle, with the byte accepted at cycle T:
  - T+1: o_cs[mod]=1, o_fetch_cmd=1.
  - T+2 (CAPTURE): o_cs and o_fetch_cmd = 0; sample i_data_in[mod].
  - T+3 (RESP): o_tx_byte = captured value, o_tx_valid=1 for one cycle, then -> DONE.
- WDATA:
  - On i_rx_valid at cycle T: at T+1, o_data_out=byte, o_cs[mod]=1, o_load_cmd=1 for exactly one cycle, then -> DONE.
- DONE:
  - Further bytes are ignored.
  - i_frame_end -> IDLE.
- Strobe rule: o_fetch_cmd and o_load_cmd are never high together. o_cs is high only during a strobe cycle.
- i_frame_end in any state:
  - Next state IDLE.
  - Pending transaction cancelled; no later strobe or tx.
  - A strobe already on the outputs in that cycle completes normally.
  - i_frame_end in WDATA (write data not yet received) also pulses o_frame_err.
- i_frame_end and i_rx_valid in the same cycle: frame_end wins and the byte is discarded.
- i_frame_start while not IDLE: treat as a frame restart -> CMD; any pending transaction is dropped without error.
- o_ioc and o_data_out hold their last values between transactions.
- Asynchronous reset mid-transaction: all strobes drop immediately and the FSM returns to IDLE.

Optional Feature:
- Macro: IOC_AUTO_INC_EN.
- With the macro defined (burst mode):
  - After a completed write, the next data byte in the same frame writes to ioc+1 (5-bit wrap, 31 -> 0).
  - After RESP of a read, each further received byte (a dummy byte) triggers a read of ioc+1.
  - Same timing as single accesses.
  - DONE is used only for errors.
- Without the macro: exactly one access per frame; extra bytes are ignored.

Decomposition:
- Shared package ioc_pkg holds:
  - FSM state enum.
  - Command bit positions: CMD_DIR_BIT=7, CMD_MOD_MSB=6, CMD_MOD_LSB=5, CMD_IOC_W=5.
  - DIR_WRITE=1'b1.
- One natural sub-module, ioc_rd_mux: selects i_data_in by module index and registers the capture.

Test Plan:
- Write: frame_start, bytes 0x86, 0x35 -> one cycle with o_cs=0001, o_ioc=6, o_data_out=0x35, o_load_cmd=1; no o_tx_valid.
- Read: byte 0x06 with module-0 data 0xA5 -> o_fetch_cmd one cycle at T+1; o_tx_valid with o_tx_byte=0xA5 at T+3.
- Truncated write: bytes 0xA7 then frame_end with no data byte -> no o_load_cmd; o_frame_err pulse; o_busy=0 afterwards.
- Extra bytes, macro off: 0x86, 0x11, 0x22 -> exactly one load, to ioc 6 with data 0x11.
- Collision: frame_end and i_rx_valid in the same cycle while in CMD -> byte discarded, no strobe, FSM back in IDLE.
- Burst, IOC_AUTO_INC_EN defined: 0x9F, 0x01, 0x02 -> loads to ioc 31 then ioc 0 on module 0; with NUM_MODULES=2, command 0xC0 -> o_frame_err, no strobe.

Source files
------------

// File: rtl/ioc_pkg.sv
// ioc_pkg: shared FSM states and command-byte field positions for the IOC register bus
package ioc_pkg;
   typedef enum logic [2:0] {IDLE, CMD, WDATA, FETCH, CAPTURE, RESP, DONE} ioc_state_e;
   localparam int CMD_DIR_BIT = 7;
   localparam int CMD_MOD_MSB = 6;
   localparam int CMD_MOD_LSB = 5;
   localparam int CMD_IOC_W   = 5;
   localparam logic DIR_WRITE = 1'b1;
endpackage

// File: rtl/ioc_rd_mux.sv
// ioc_rd_mux: picks the addressed module's read bus and registers the captured byte
module ioc_rd_mux #(
   parameter int NUM_MODULES = 4
) (
   input  logic                       i_sys_clk,
   input  logic                       i_rst_b,
   input  logic                       capture,
   input  logic [1:0]                 sel,
   input  logic [8*NUM_MODULES-1:0]   data_in,
   output logic [7:0]                 q
);
   logic [7:0] pick;
   // select the addressed module's byte; unused indices read as zero
   always_comb begin
      pick = '0;
      for (int k = 0; k < NUM_MODULES; k++)
         if (sel == 2'(k)) pick = data_in[8*k +: 8];
   end
   // hold the captured read byte until the next capture
   always_ff @(posedge i_sys_clk or negedge i_rst_b)
      if (!i_rst_b) q <= '0;
      else if (capture) q <= pick;
endmodule

// File: rtl/ioc_cmd_initiator.sv
// ioc_cmd_initiator: turns SPI host bytes into IOC module strobes; IOC_AUTO_INC_EN enables burst auto-increment
module ioc_cmd_initiator
   import ioc_pkg::*;
#(
   parameter int NUM_MODULES = 4
) (
   input  logic                       i_sys_clk,
   input  logic                       i_rst_b,
   input  logic                       i_frame_start,
   input  logic                       i_frame_end,
   input  logic [7:0]                 i_rx_byte,
   input  logic                       i_rx_valid,
   output logic [7:0]                 o_tx_byte,
   output logic                       o_tx_valid,
   output logic [4:0]                 o_ioc,
   output logic [7:0]                 o_data_out,
   output logic [NUM_MODULES-1:0]     o_cs,
   output logic                       o_fetch_cmd,
   output logic                       o_load_cmd,
   input  logic [8*NUM_MODULES-1:0]   i_data_in,
   output logic                       o_busy,
   output logic                       o_frame_err
);
   ioc_state_e state, state_n;
   logic [1:0] mod, mod_n;
   logic inc, inc_n;
   logic [4:0] ioc_n;
   logic [7:0] data_n;
   logic [NUM_MODULES-1:0] cs_n;
   logic fetch_n, load_n, txv_n, err_n, cap;
   logic [1:0] rx_mod;
   assign rx_mod = i_rx_byte[CMD_MOD_MSB:CMD_MOD_LSB];
   // state register
   always_ff @(posedge i_sys_clk or negedge i_rst_b)
      if (!i_rst_b) state <= IDLE;
      else state <= state_n;
   // next state and next registered outputs; frame_end beats everything, then frame restart
   always_comb begin
      state_n = state;
      mod_n   = mod;
      inc_n   = inc;
      ioc_n   = o_ioc;
      data_n  = o_data_out;
      cs_n    = '0;
      fetch_n = 1'b0;
      load_n  = 1'b0;
      txv_n   = 1'b0;
      err_n   = 1'b0;
      cap     = 1'b0;
      if (i_frame_end) begin
         state_n = IDLE;
         err_n   = (state == WDATA) && !inc;
      end else if (i_frame_start) begin
         state_n = CMD;
         inc_n   = 1'b0;
      end else begin
         case (state)
            CMD:
               if (i_rx_valid) begin
                  ioc_n = i_rx_byte[CMD_IOC_W-1:0];
                  mod_n = rx_mod;
                  inc_n = 1'b0;
                  if ({1'b0, rx_mod} >= 3'(NUM_MODULES)) begin
                     err_n   = 1'b1;
                     state_n = DONE;
                  end else if (i_rx_byte[CMD_DIR_BIT] == DIR_WRITE) begin
                     state_n = WDATA;
                  end else begin
                     fetch_n = 1'b1;
                     cs_n    = NUM_MODULES'(1) << rx_mod;
                     state_n = FETCH;
                  end
               end
            WDATA:
               if (i_rx_valid) begin
                  data_n = i_rx_byte;
                  ioc_n  = o_ioc + {4'b0, inc};
                  load_n = 1'b1;
                  cs_n   = NUM_MODULES'(1) << mod;
`ifdef IOC_AUTO_INC_EN
                  inc_n   = 1'b1;
                  state_n = WDATA;
`else
                  state_n = DONE;
`endif
               end
            FETCH:
               state_n = CAPTURE;
            CAPTURE: begin
               cap     = 1'b1;
               txv_n   = 1'b1;
               state_n = RESP;
            end
            RESP:
`ifdef IOC_AUTO_INC_EN
               if (i_rx_valid) begin
                  ioc_n   = o_ioc + 5'd1;
                  fetch_n = 1'b1;
                  cs_n    = NUM_MODULES'(1) << mod;
                  state_n = FETCH;
               end
`else
               state_n = DONE;
`endif
            default: ;
         endcase
      end
   end
   // registered outputs and latched command fields
   always_ff @(posedge i_sys_clk or negedge i_rst_b)
      if (!i_rst_b) begin
         mod         <= '0;
         inc         <= 1'b0;
         o_ioc       <= '0;
         o_data_out  <= '0;
         o_cs        <= '0;
         o_fetch_cmd <= 1'b0;
         o_load_cmd  <= 1'b0;
         o_tx_valid  <= 1'b0;
         o_frame_err <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         mod         <= mod_n;
         inc         <= inc_n;
         o_ioc       <= ioc_n;
         o_data_out  <= data_n;
         o_cs        <= cs_n;
         o_fetch_cmd <= fetch_n;
         o_load_cmd  <= load_n;
         o_tx_valid  <= txv_n;
         o_frame_err <= err_n;
         o_busy      <= (state_n != IDLE);
      end
   ioc_rd_mux #(.NUM_MODULES(NUM_MODULES)) u_rd_mux (
      .i_sys_clk (i_sys_clk),
      .i_rst_b   (i_rst_b),
      .capture   (cap),
      .sel       (mod),
      .data_in   (i_data_in),
      .q         (o_tx_byte)
   );
endmodule
